// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter
// Shares one APB bus between two internal requesters with round-robin
// arbitration. Each accepted request runs through SETUP and ACCESS toward
// slave 1 (addr MSB = 1) or slave 2 (addr MSB = 0). Completion comes back as
// a one-cycle registered response pulse with read data and an error flag. A
// wait-state timeout aborts a transfer whose slave never raises PREADY.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata 0|1
//                            request handshake per requester; ready is
//                            combinational in the accept slot
//   rsp_valid0/1, rsp_rdata, rsp_err
//                            registered completion pulse and its payload
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
//                            registered APB master outputs
//   PREADY, PRDATA, PSLVERR  muxed return path from the selected slave
module apb_rr_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid0,
  output logic              req_ready0,
  input  logic              req_write0,
  input  logic [ADDR_W:0]   req_addr0,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic              req_valid1,
  output logic              req_ready1,
  input  logic              req_write1,
  input  logic [ADDR_W:0]   req_addr1,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_next_s;
  logic                last_grant_r;  // also identifies the owner of the transfer in flight
  logic [CNT_W-1:0]    tcnt_r;
  logic                psel1_r;
  logic                psel2_r;
  logic                penable_r;
  logic                pwrite_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r;
  logic                rsp_valid0_r;
  logic                rsp_valid1_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;

  logic                in_access_s;
  logic                done_s;
  logic                timeout_s;
  logic                slot_s;
  logic                gnt0_s;
  logic                gnt1_s;
  logic                accept_s;
  logic                cap_write_s;
  logic [ADDR_W:0]     cap_addr_s;
  logic [DATA_W-1:0]   cap_wdata_s;

  // The timeout abort needs PREADY=0, so it can never coincide with an accept.
  // The slot is gated by PRESETn so ready stays low while reset is held.
  assign in_access_s = (state_r == ST_ACCESS);
  assign done_s      = in_access_s && PREADY;
  assign timeout_s   = in_access_s && !PREADY && (tcnt_r == TMO_LAST);
  assign slot_s      = PRESETn && ((state_r == ST_IDLE) || done_s);

  // On contention the requester that did not win last time is granted.
  assign gnt0_s   = req_valid0 && (!req_valid1 || last_grant_r);
  assign gnt1_s   = req_valid1 && (!req_valid0 || !last_grant_r);
  assign accept_s = slot_s && (req_valid0 || req_valid1);

  assign req_ready0 = slot_s && gnt0_s;
  assign req_ready1 = slot_s && gnt1_s;

  assign cap_write_s = gnt1_s ? req_write1 : req_write0;
  assign cap_addr_s  = gnt1_s ? req_addr1  : req_addr0;
  assign cap_wdata_s = gnt1_s ? req_wdata1 : req_wdata0;

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: back-to-back accept from ACCESS skips the IDLE bubble.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done_s) begin
          if (accept_s) begin
            state_next_s = ST_SETUP;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Round-robin history; reset value makes requester 0 win the first contention.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= gnt1_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Wait-state counter: counts ACCESS cycles without PREADY, cleared on accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_r <= '0;
    end else if (accept_s || timeout_s) begin
      tcnt_r <= '0;
    end else if (in_access_s && !PREADY) begin
      tcnt_r <= tcnt_r + CNT_W'(1);
    end else begin
      tcnt_r <= tcnt_r;
    end
  end

  // APB output registers: loaded for SETUP on accept, PENABLE raised for ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel1_r   <= 1'b0;
      psel2_r   <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= '0;
      pwdata_r  <= '0;
    end else if (accept_s) begin
      psel1_r   <= cap_addr_s[ADDR_W];
      psel2_r   <= ~cap_addr_s[ADDR_W];
      penable_r <= 1'b0;
      pwrite_r  <= cap_write_s;
      paddr_r   <= cap_addr_s[ADDR_W-1:0];
      pwdata_r  <= cap_wdata_s;
    end else if (state_r == ST_SETUP) begin
      penable_r <= 1'b1;
    end else if (done_s || timeout_s) begin
      psel1_r   <= 1'b0;
      psel2_r   <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      penable_r <= penable_r;
    end
  end

  // Response pulse: zero payload outside the pulse, reads only return PRDATA.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
      rsp_rdata_r  <= '0;
      rsp_err_r    <= 1'b0;
    end else begin
      rsp_valid0_r <= (done_s || timeout_s) && !last_grant_r;
      rsp_valid1_r <= (done_s || timeout_s) && last_grant_r;
      rsp_rdata_r  <= (done_s && !pwrite_r) ? PRDATA : '0;
      rsp_err_r    <= timeout_s || (done_s && PSLVERR);
    end
  end

  assign PSEL1      = psel1_r;
  assign PSEL2      = psel2_r;
  assign PENABLE    = penable_r;
  assign PWRITE     = pwrite_r;
  assign PADDR      = paddr_r;
  assign PWDATA     = pwdata_r;
  assign rsp_valid0 = rsp_valid0_r;
  assign rsp_valid1 = rsp_valid1_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Self-checking bench for apb_rr_master_arbiter: a configurable slave model,
// a requester driver, and a scoreboard of expected responses and bus phases
// filled when a request is accepted and drained when the DUT produces them.
module tb_apb_rr_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req_valid0, req_valid1;
  logic          req_ready0, req_ready1;
  logic          req_write0, req_write1;
  logic [AW:0]   req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic          rsp_valid0, rsp_valid1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  typedef struct {
    bit          who;
    logic [31:0] rdata;
    bit          err;
    int          alen;
  } rsp_t;

  typedef struct {
    bit          w;
    logic [32:0] a;
    logic [31:0] d;
  } bus_t;

  rsp_t exp_q[$];
  bus_t bus_q[$];
  int   acc_order[$];

  int n_tests = 0;
  int n_fail  = 0;
  int issue0 = 0, issue1 = 0;
  int acc0_cnt = 0, acc1_cnt = 0;
  int flush_req = 0, flush_done = 0;

  int          slv_wait  = 0;
  logic [31:0] slv_rdata = 32'd0;
  bit          slv_err   = 1'b0;
  bit          slv_hang  = 1'b0;
  int          slv_cnt   = 0;

  logic [66:0] cur_bus;
  int          acc_len = 0;

  apb_rr_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_write0(req_write0),
    .req_addr0(req_addr0), .req_wdata0(req_wdata0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_write1(req_write1),
    .req_addr1(req_addr1), .req_wdata1(req_wdata1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record what the accepted request must produce on the bus and as a response.
  function automatic void push_req(input bit who, input bit w, input logic [32:0] a, input logic [31:0] d);
    rsp_t e;
    bus_t b;
    e.who   = who;
    e.err   = slv_hang ? 1'b1 : slv_err;
    e.rdata = (w || slv_hang) ? 32'd0 : slv_rdata;
    e.alen  = slv_hang ? TMO : slv_wait + 1;
    b.w = w;
    b.a = a;
    b.d = d;
    exp_q.push_back(e);
    bus_q.push_back(b);
    acc_order.push_back(int'(who));
  endfunction

  // Slave model: PREADY after slv_wait ACCESS cycles, never when hanging.
  always @(negedge PCLK) begin
    if (PENABLE && (PSEL1 || PSEL2)) begin
      PREADY = !slv_hang && (slv_cnt >= slv_wait);
      slv_cnt++;
    end else begin
      PREADY  = 1'b0;
      slv_cnt = 0;
    end
    PRDATA  = slv_rdata;
    PSLVERR = slv_err && PREADY;
  end

  // Requester driver: a request stays valid until the monitor has seen it accepted.
  always @(posedge PCLK) begin
    #1;
    req_valid0 = (acc0_cnt < issue0);
    req_valid1 = (acc1_cnt < issue1);
  end

  // Monitor: response scoreboard, bus phase checks, accept capture.
  always @(negedge PCLK) begin : mon
    rsp_t e;
    bus_t b;
    #1;
    if (flush_done != flush_req) begin
      exp_q.delete();
      bus_q.delete();
      flush_done = flush_req;
    end
    if (rsp_valid0 || rsp_valid1) begin
      check_eq("rsp_onehot", {rsp_valid0 & rsp_valid1}, 0);
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_who", rsp_valid1, e.who);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_err", rsp_err, e.err);
        check_eq("access_len", acc_len, e.alen);
      end
    end else begin
      check_eq("rsp_idle_zero", {rsp_rdata, rsp_err}, 0);
    end
    if (PSEL1 || PSEL2) begin
      check_eq("psel_onehot", {PSEL1 ^ PSEL2}, 1);
      if (!PENABLE) begin
        acc_len = 0;
        if (bus_q.size() == 0) begin
          check_eq("setup_unexpected", 1, 0);
        end else begin
          b = bus_q.pop_front();
          check_eq("setup_psel1", PSEL1, b.a[32]);
          check_eq("setup_paddr", PADDR, b.a[31:0]);
          check_eq("setup_pwrite", PWRITE, b.w);
          if (b.w) check_eq("setup_pwdata", PWDATA, b.d);
        end
        cur_bus = {PSEL1, PSEL2, PWRITE, PADDR, PWDATA};
      end else begin
        acc_len++;
        check_eq("access_stable", {PSEL1, PSEL2, PWRITE, PADDR, PWDATA}, cur_bus);
      end
    end
    if (req_ready0 || req_ready1) begin
      check_eq("ready_onehot", {req_ready0 & req_ready1}, 0);
    end
    if (req_ready0) begin
      check_eq("ready0_valid", req_valid0, 1);
      push_req(1'b0, req_write0, req_addr0, req_wdata0);
      acc0_cnt++;
    end
    if (req_ready1) begin
      check_eq("ready1_valid", req_valid1, 1);
      push_req(1'b1, req_write1, req_addr1, req_wdata1);
      acc1_cnt++;
    end
  end

  task automatic sync_drive();
    @(posedge PCLK);
    #2;
  endtask

  task automatic issue(input int n, input bit w, input logic [32:0] a, input logic [31:0] d);
    if (n == 0) begin
      req_write0 = w; req_addr0 = a; req_wdata0 = d; issue0++;
    end else begin
      req_write1 = w; req_addr1 = a; req_wdata1 = d; issue1++;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      #2;
      if (exp_q.size() == 0 && bus_q.size() == 0 && !PSEL1 && !PSEL2 &&
          acc0_cnt >= issue0 && acc1_cnt >= issue1) break;
    end
    check_eq(tag, exp_q.size() + bus_q.size() + (issue0 - acc0_cnt) + (issue1 - acc1_cnt), 0);
  endtask

  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      #2;
      if (rsp_valid0 || rsp_valid1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq(tag, 0, 1);
  endtask

  initial begin : watchdog
    #60000;
    check_eq("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    int base;
    bit seen;
    PRESETn = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_write0 = 1'b0; req_write1 = 1'b0;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    #2;
    check_eq("reset_bus", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    check_eq("reset_rsp", {rsp_valid0, rsp_valid1, rsp_err, rsp_rdata, req_ready0, req_ready1}, 0);
    PRESETn = 1'b1;

    // Contention straight after reset: requester 0 first, requester 1 back-to-back.
    slv_rdata = 32'd10;
    base = acc_order.size();
    sync_drive();
    issue(0, 1'b1, {1'b0, 32'd4}, 32'd50);
    issue(1, 1'b0, {1'b1, 32'd0}, 32'd0);
    wait_rsp("t2_rsp_wait");
    check_eq("t2_first_rsp_is_0", {rsp_valid0, rsp_valid1}, 2'b10);
    check_eq("t2_back_to_back_setup", {PSEL1, PSEL2, PENABLE}, 3'b100);
    wait_idle("t2_drain");
    check_eq("t2_order_n", acc_order.size() - base, 2);
    if (acc_order.size() - base >= 2) begin
      check_eq("t2_order_first", acc_order[base], 0);
      check_eq("t2_order_second", acc_order[base+1], 1);
    end

    // Second simultaneous pair alternates back to requester 0.
    base = acc_order.size();
    sync_drive();
    issue(0, 1'b0, {1'b1, 32'd8}, 32'd0);
    issue(1, 1'b1, {1'b0, 32'd12}, 32'd77);
    wait_idle("t2b_drain");
    if (acc_order.size() > base) check_eq("t2b_alternate", acc_order[base], 0);

    // Single write to slave 1, PREADY immediately; then the bus goes idle.
    slv_rdata = 32'h0000_00AA;
    sync_drive();
    issue(0, 1'b1, {1'b1, 32'd0}, 32'd10);
    wait_rsp("t1_rsp_wait");
    check_eq("t1_idle_after", {PSEL1, PSEL2, PENABLE}, 0);
    wait_idle("t1_drain");

    // Requester 0 won last, so a contention now goes to requester 1.
    base = acc_order.size();
    sync_drive();
    issue(0, 1'b1, {1'b0, 32'd20}, 32'd33);
    issue(1, 1'b0, {1'b1, 32'd21}, 32'd0);
    wait_idle("t1b_drain");
    if (acc_order.size() > base) check_eq("t1b_rr_to_1", acc_order[base], 1);

    // Wait states: 3 low cycles, ACCESS lasts 4.
    slv_wait = 3;
    slv_rdata = 32'd80;
    sync_drive();
    issue(1, 1'b0, {1'b0, 32'd7}, 32'd0);
    wait_idle("t3_drain");

    // Timeout; a second request waiting during the abort must not be taken then.
    slv_hang = 1'b1;
    slv_rdata = 32'hDEAD_BEEF;
    sync_drive();
    issue(0, 1'b0, {1'b1, 32'd5}, 32'd0);
    repeat (4) sync_drive();
    issue(1, 1'b0, {1'b0, 32'd6}, 32'd0);
    wait_rsp("t4_rsp_wait");
    check_eq("t4_bus_dropped", {PSEL1, PSEL2, PENABLE}, 0);
    wait_idle("t4_drain");
    slv_hang = 1'b0;

    // Slave error on a read: error flag with PRDATA still returned.
    slv_wait = 1;
    slv_err = 1'b1;
    slv_rdata = 32'h0000_1234;
    sync_drive();
    issue(0, 1'b0, {1'b1, 32'd3}, 32'd0);
    wait_idle("t5_drain");
    slv_err = 1'b0;

    // Reset in the middle of ACCESS.
    slv_wait = 6;
    sync_drive();
    issue(1, 1'b1, {1'b0, 32'd9}, 32'd99);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      #2;
      if (PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t6_reach_access", seen, 1);
    @(posedge PCLK);
    #3;
    PRESETn = 1'b0;
    #1;
    check_eq("t6_reset_bus", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    check_eq("t6_reset_rsp", {rsp_valid0, rsp_valid1, rsp_err, rsp_rdata}, 0);
    flush_req++;
    slv_wait = 0;
    base = acc_order.size();
    issue(0, 1'b0, {1'b1, 32'd1}, 32'd0);
    issue(1, 1'b0, {1'b0, 32'd2}, 32'd0);
    repeat (2) @(negedge PCLK);
    #2;
    check_eq("t6_no_ready_in_reset", {req_ready0, req_ready1}, 0);
    @(posedge PCLK);
    #3;
    PRESETn = 1'b1;
    wait_idle("t6_drain");
    check_eq("t6_order_n", acc_order.size() - base, 2);
    if (acc_order.size() > base) check_eq("t6_first_after_reset", acc_order[base], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
